// File: rtl/fetch_ctrl.sv
// Fetch-stage PC controller: boot sequencing, sequential/redirect PC selection,
// and deferral of redirects that arrive while the pipeline is stalled.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] jal_target,
  input  logic [31:0] alu_target,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_if,
  output logic [31:0] pc_id,
  output logic        id_valid,
  output logic        flush_id,
  output logic        sel_err,
  output logic [31:0] redirect_cnt
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pend_target, pend_target_nxt;
  logic [31:0] pc_if_nxt, pc_id_nxt, redirect_cnt_nxt;
  logic        id_valid_nxt, sel_err_nxt;
  logic [31:0] seq_pc, sel_target;
  logic        is_redirect;

  assign seq_pc      = pc_if + 32'd4;
  assign is_redirect = (pc_sel == 2'b01) || (pc_sel == 2'b10);
  assign sel_target  = (pc_sel == 2'b01) ? {jal_target[31:2], 2'b00}
                                         : {alu_target[31:2], 2'b00};

  always_comb begin
    state_nxt        = state;
    pend_target_nxt  = pend_target;
    pc_if_nxt        = pc_if;
    pc_id_nxt        = pc_id;
    id_valid_nxt     = id_valid;
    sel_err_nxt      = sel_err;
    redirect_cnt_nxt = redirect_cnt;
    imem_addr        = RESET_PC;
    flush_id         = 1'b0;

    unique case (state)
      BOOT: begin
        if (!stall) begin
          pc_if_nxt    = RESET_PC;
          id_valid_nxt = 1'b0;
          state_nxt    = RUN;
        end
      end
      RUN: begin
        if (pc_sel == 2'b11) sel_err_nxt = 1'b1;
        if (stall) begin
          imem_addr = pc_if;
          if (is_redirect) begin
            pend_target_nxt = sel_target;
            state_nxt       = PEND;
          end
        end else if (is_redirect) begin
          imem_addr        = sel_target;
          flush_id         = 1'b1;
          pc_if_nxt        = sel_target;
          pc_id_nxt        = pc_if;
          id_valid_nxt     = 1'b0;
          redirect_cnt_nxt = redirect_cnt + 32'd1;
        end else begin
          imem_addr    = seq_pc;
          pc_if_nxt    = seq_pc;
          pc_id_nxt    = pc_if;
          id_valid_nxt = 1'b1;
        end
      end
      PEND: begin
        // pc_sel is ignored here; the latched target is the only redirect source
        if (stall) begin
          imem_addr = pc_if;
        end else begin
          imem_addr        = pend_target;
          flush_id         = 1'b1;
          pc_if_nxt        = pend_target;
          pc_id_nxt        = pc_if;
          id_valid_nxt     = 1'b0;
          redirect_cnt_nxt = redirect_cnt + 32'd1;
          pend_target_nxt  = '0;
          state_nxt        = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase

    if (rst) begin
      imem_addr = RESET_PC;
      flush_id  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= BOOT;
      pc_if        <= RESET_PC;
      pc_id        <= '0;
      id_valid     <= 1'b0;
      pend_target  <= '0;
      sel_err      <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      state        <= state_nxt;
      pc_if        <= pc_if_nxt;
      pc_id        <= pc_id_nxt;
      id_valid     <= id_valid_nxt;
      pend_target  <= pend_target_nxt;
      sel_err      <= sel_err_nxt;
      redirect_cnt <= redirect_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl: boot, jumps, stalled redirects,
// reserved select, reset during a pending redirect and address wrap.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic [1:0]  pc_sel;
  logic [31:0] jal_target, alu_target;
  logic [31:0] imem_addr, pc_if, pc_id, redirect_cnt;
  logic        id_valid, flush_id, sel_err;

  int total = 0;
  int bad   = 0;

  fetch_ctrl #(.RESET_PC(32'h4000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_sel(pc_sel),
    .jal_target(jal_target), .alu_target(alu_target),
    .imem_addr(imem_addr), .pc_if(pc_if), .pc_id(pc_id),
    .id_valid(id_valid), .flush_id(flush_id), .sel_err(sel_err),
    .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle so inputs driven next are away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; pc_sel = 2'b00;
    jal_target = '0; alu_target = '0;
    #1;
    step();
    stall = 1'b1; pc_sel = 2'b01; jal_target = 32'h1234_5678;
    #1;
    chk("rst_imem", imem_addr, 32'h4000_0000);
    chk("rst_flush", {31'd0, flush_id}, 32'd0);
    step();
    chk("rst_pc_if", pc_if, 32'h4000_0000);
    chk("rst_pc_id", pc_id, 32'd0);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_sel_err", {31'd0, sel_err}, 32'd0);
    chk("rst_cnt", redirect_cnt, 32'd0);

    // Boot
    rst = 1'b0; stall = 1'b0; pc_sel = 2'b00;
    #1;
    chk("boot_imem", imem_addr, 32'h4000_0000);
    chk("boot_flush", {31'd0, flush_id}, 32'd0);
    step();
    chk("run0_pc_if", pc_if, 32'h4000_0000);
    chk("run0_imem", imem_addr, 32'h4000_0004);
    chk("run0_id_valid", {31'd0, id_valid}, 32'd0);
    step();
    chk("run1_pc_id", pc_id, 32'h4000_0000);
    chk("run1_id_valid", {31'd0, id_valid}, 32'd1);
    chk("run1_pc_if", pc_if, 32'h4000_0004);
    step(); step(); step();
    chk("seq_pc_if", pc_if, 32'h4000_0010);

    // JAL with unaligned target
    pc_sel = 2'b01; jal_target = 32'h4000_0103;
    #1;
    chk("jal_imem", imem_addr, 32'h4000_0100);
    chk("jal_flush", {31'd0, flush_id}, 32'd1);
    step();
    pc_sel = 2'b00;
    chk("jal_pc_if", pc_if, 32'h4000_0100);
    chk("jal_id_valid", {31'd0, id_valid}, 32'd0);
    chk("jal_pc_id", pc_id, 32'h4000_0010);
    chk("jal_cnt", redirect_cnt, 32'd1);

    // Back-to-back redirects
    pc_sel = 2'b10; alu_target = 32'h4000_0300;
    #1;
    chk("b2b1_imem", imem_addr, 32'h4000_0300);
    chk("b2b1_flush", {31'd0, flush_id}, 32'd1);
    step();
    pc_sel = 2'b01; jal_target = 32'h4000_0400;
    #1;
    chk("b2b2_imem", imem_addr, 32'h4000_0400);
    step();
    pc_sel = 2'b00;
    chk("b2b_pc_if", pc_if, 32'h4000_0400);
    chk("b2b_pc_id", pc_id, 32'h4000_0300);
    chk("b2b_cnt", redirect_cnt, 32'd3);

    // Stalled branch deferred through PEND
    stall = 1'b1; pc_sel = 2'b10; alu_target = 32'h4000_0200;
    #1;
    chk("stb1_flush", {31'd0, flush_id}, 32'd0);
    chk("stb1_imem", imem_addr, 32'h4000_0400);
    step();
    alu_target = 32'h0; pc_sel = 2'b01; jal_target = 32'h4000_0900;
    #1;
    chk("stb2_flush", {31'd0, flush_id}, 32'd0);
    chk("stb2_imem", imem_addr, 32'h4000_0400);
    chk("stb2_cnt", redirect_cnt, 32'd3);
    step();
    chk("stb3_imem", imem_addr, 32'h4000_0400);
    chk("stb3_pc_if", pc_if, 32'h4000_0400);
    step();
    stall = 1'b0; pc_sel = 2'b00;
    #1;
    chk("stb_rel_imem", imem_addr, 32'h4000_0200);
    chk("stb_rel_flush", {31'd0, flush_id}, 32'd1);
    step();
    chk("stb_pc_if", pc_if, 32'h4000_0200);
    chk("stb_pc_id", pc_id, 32'h4000_0400);
    chk("stb_id_valid", {31'd0, id_valid}, 32'd0);
    chk("stb_cnt", redirect_cnt, 32'd4);
    step();
    chk("stb_cnt_once", redirect_cnt, 32'd4);
    chk("stb_seq_pc_if", pc_if, 32'h4000_0204);

    // Reserved select at 4000_0020
    pc_sel = 2'b01; jal_target = 32'h4000_0020;
    step();
    pc_sel = 2'b11;
    #1;
    chk("rsv_pc_if", pc_if, 32'h4000_0020);
    chk("rsv_imem", imem_addr, 32'h4000_0024);
    chk("rsv_flush", {31'd0, flush_id}, 32'd0);
    step();
    pc_sel = 2'b00;
    chk("rsv_sel_err", {31'd0, sel_err}, 32'd1);
    chk("rsv_cnt", redirect_cnt, 32'd5);
    step();
    chk("rsv_sticky", {31'd0, sel_err}, 32'd1);

    // Reset while a redirect is pending
    stall = 1'b1; pc_sel = 2'b10; alu_target = 32'h4000_0500;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; pc_sel = 2'b00;
    #1;
    chk("rpend_boot_imem", imem_addr, 32'h4000_0000);
    chk("rpend_sel_err", {31'd0, sel_err}, 32'd0);
    chk("rpend_cnt", redirect_cnt, 32'd0);
    step();
    chk("boot_hold_imem", imem_addr, 32'h4000_0000);
    chk("boot_hold_flush", {31'd0, flush_id}, 32'd0);
    stall = 1'b0;
    step();
    chk("rpend_pc_if", pc_if, 32'h4000_0000);
    chk("rpend_imem", imem_addr, 32'h4000_0004);

    // Wrap-around
    pc_sel = 2'b01; jal_target = 32'hFFFF_FFFF;
    #1;
    chk("wrap_tgt_imem", imem_addr, 32'hFFFF_FFFC);
    step();
    pc_sel = 2'b00;
    #1;
    chk("wrap_pc_if", pc_if, 32'hFFFF_FFFC);
    chk("wrap_imem", imem_addr, 32'h0000_0000);
    step();
    chk("wrap_pc_if_next", pc_if, 32'h0000_0000);
    chk("wrap_pc_id", pc_id, 32'hFFFF_FFFC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h4000_0000, first fetch address after reset.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port stall  input  1  pipeline hold request; PC and decode slot frozen while 1.
REQ-005 SHALL provide port pc_sel  input  2  PC source: 00 sequential, 01 JAL target, 10 branch/JALR target, 11 reserved.
REQ-006 SHALL provide port jal_target  input  32  JAL destination address.
REQ-007 SHALL provide port alu_target  input  32  branch/JALR destination address.
REQ-008 SHALL provide port imem_addr  output  32  combinational address to synchronous-read IMEM; data returns next cycle.
REQ-009 SHALL provide port pc_if  output  32  registered PC of the fetch whose IMEM data is valid this cycle.
REQ-010 SHALL provide port pc_id  output  32  registered PC of the instruction in decode.
REQ-011 SHALL provide port id_valid  output  1  registered; 1 = decode slot holds a real instruction, 0 = bubble.
REQ-012 SHALL provide port flush_id  output  1  combinational; 1 in the cycle a redirect is applied, decode entry must be bubbled.
REQ-013 SHALL provide port sel_err  output  1  sticky flag, set on pc_sel==11 in RUN.
REQ-014 SHALL provide port redirect_cnt  output  32  count of applied redirects, wraps mod 2^32.

Function
REQ-015 SHALL implement states BOOT, RUN, PEND.
REQ-016 SHALL compute target = selected input with bits[1:0] forced to 00; sequential next = pc_if + 4, mod 2^32.
REQ-017 BOOT: imem_addr=RESET_PC; if stall=0, edge loads pc_if<=RESET_PC, id_valid<=0, goes RUN; if stall=1, stays BOOT.
REQ-018 RUN, stall=0, pc_sel 00 or 11: imem_addr=pc_if+4; edge: pc_if<=pc_if+4, pc_id<=pc_if, id_valid<=1.
REQ-019 RUN, stall=0, pc_sel 01/10: imem_addr=target, flush_id=1; edge: pc_if<=target, pc_id<=pc_if, id_valid<=0, redirect_cnt+1.
REQ-020 RUN, stall=1, pc_sel 00/11: imem_addr=pc_if (re-read); pc_if, pc_id, id_valid hold; flush_id=0.
REQ-021 RUN, stall=1, pc_sel 01/10: latch target into pending register, go PEND; imem_addr=pc_if; others hold; flush_id=0.
REQ-022 PEND, stall=1: hold all; pc_sel ignored; pending target not overwritten.
REQ-023 PEND, stall=0: apply pending target exactly as REQ-019 (pc_sel ignored), clear pending, go RUN.
REQ-024 sel_err SHALL set on the edge of any RUN cycle with pc_sel==11 (stalled or not); cleared only by rst.
REQ-025 flush_id SHALL be 0 in BOOT and whenever stall=1.
REQ-026 Each redirect SHALL increment redirect_cnt exactly once, at application, never at latch.
REQ-027 Back-to-back redirects in consecutive unstalled RUN cycles SHALL each be applied and counted.

Reset
REQ-028 rst=1 at an edge SHALL force state BOOT, pc_if=RESET_PC, pc_id=0, id_valid=0, pending cleared, sel_err=0, redirect_cnt=0, from any state.
REQ-029 While rst=1, imem_addr=RESET_PC and flush_id=0; rst overrides stall and pc_sel.

Verification
REQ-030 Boot: rst 2 cycles, then stall=0, pc_sel=00 -> imem_addr 4000_0000, 4000_0000, 4000_0004; pc_id=4000_0000 with id_valid=1 on 3rd post-reset edge.
REQ-031 JAL: pc_if=4000_0010, pc_sel=01, jal_target=4000_0103 -> imem_addr=4000_0100, flush_id=1; next cycle pc_if=4000_0100, id_valid=0, redirect_cnt=1.
REQ-032 Stalled branch: pc_sel=10, alu_target=4000_0200, stall=1 for 3 cycles, alu_target changed to 0 on cycle 2 -> PEND, flush_id=0, imem_addr=pc_if; on stall drop imem_addr=4000_0200, flush_id=1, cnt+1 once.
REQ-033 Reserved: pc_sel=11 at pc_if=4000_0020 -> imem_addr=4000_0024, no flush, sel_err=1 and stays 1.
REQ-034 Reset in PEND: rst during PEND -> BOOT, pending dropped; after release first fetch 4000_0000, not pending target.
REQ-035 Wrap: pc_if=FFFF_FFFC, pc_sel=00 -> imem_addr=0000_0000.
